alu_operand_stage: RTL



---
 rtl/rv32i_ex_pkg.sv | 33 +++
 rtl/alu_operand_stage_if.sv | 57 +++++
 rtl/alu_operand_stage_fwd_mux.sv | 36 +++
 rtl/alu_operand_stage.sv | 139 +++++++++++++
 4 files changed

// File: rtl/rv32i_ex_pkg.sv
// Shared EX-side types for the ALU operand stage.
// Operand select encodings, default widths and the payload bundle.
package rv32i_ex_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [1:0] SEL_A_RS1  = 2'b00;
  localparam logic [1:0] SEL_A_PC   = 2'b01;
  localparam logic [1:0] SEL_A_ZERO = 2'b10;

  localparam logic [1:0] SEL_B_RS2  = 2'b00;
  localparam logic [1:0] SEL_B_IMM  = 2'b01;
  localparam logic [1:0] SEL_B_FOUR = 2'b10;

  localparam logic [XLEN-1:0] CONST_FOUR = XLEN'(4);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]      a_op;
    logic [XLEN-1:0]      b_op;
    logic [2:0]           func;
    logic                 sub_sra;
    logic [REG_IDX_W-1:0] rd;
    logic                 rd_we;
  } payload_t;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode-side and ALU-side signal bundle of the operand stage.
// slave = the stage itself, master = whoever drives and consumes it.
interface alu_operand_stage_if
  import rv32i_ex_pkg::*;
();

  logic                 in_valid;
  logic                 in_ready;
  logic [REG_IDX_W-1:0] rs1_idx;
  logic [REG_IDX_W-1:0] rs2_idx;
  logic [XLEN-1:0]      rs1_val;
  logic [XLEN-1:0]      rs2_val;
  logic [XLEN-1:0]      pc;
  logic [XLEN-1:0]      imm;
  logic [1:0]           sel_a;
  logic [1:0]           sel_b;
  logic [2:0]           func_in;
  logic                 sub_sra_in;
  logic [REG_IDX_W-1:0] rd_in;
  logic                 rd_we_in;
  logic [REG_IDX_W-1:0] fwd_em_rd;
  logic [REG_IDX_W-1:0] fwd_mw_rd;
  logic                 fwd_em_we;
  logic                 fwd_mw_we;
  logic [XLEN-1:0]      fwd_em_val;
  logic [XLEN-1:0]      fwd_mw_val;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      a_op;
  logic [XLEN-1:0]      b_op;
  logic [2:0]           func;
  logic                 sub_sra;
  logic [REG_IDX_W-1:0] rd;
  logic                 rd_we;

  modport slave (
    input  in_valid, rs1_idx, rs2_idx, rs1_val, rs2_val,
    input  pc, imm, sel_a, sel_b, func_in, sub_sra_in,
    input  rd_in, rd_we_in, fwd_em_rd, fwd_mw_rd,
    input  fwd_em_we, fwd_mw_we, fwd_em_val, fwd_mw_val,
    input  flush, out_ready,
    output in_ready, out_valid, a_op, b_op,
    output func, sub_sra, rd, rd_we
  );

  modport master (
    output in_valid, rs1_idx, rs2_idx, rs1_val, rs2_val,
    output pc, imm, sel_a, sel_b, func_in, sub_sra_in,
    output rd_in, rd_we_in, fwd_em_rd, fwd_mw_rd,
    output fwd_em_we, fwd_mw_we, fwd_em_val, fwd_mw_val,
    output flush, out_ready,
    input  in_ready, out_valid, a_op, b_op,
    input  func, sub_sra, rd, rd_we
  );

endinterface

// File: rtl/alu_operand_stage_fwd_mux.sv
// Per-source forwarding mux (EX/MEM over MEM/WB, x0 never forwarded).
// Forwarding exists only when ALU_OPERAND_FWD_EN is defined.
module operand_fwd_mux
  import rv32i_ex_pkg::*;
#(
  parameter int W  = XLEN,
  parameter int IW = REG_IDX_W
) (
  input  logic [IW-1:0] idx,
  input  logic [W-1:0]  rf_val,
  input  logic [IW-1:0] em_rd,
  input  logic          em_we,
  input  logic [W-1:0]  em_val,
  input  logic [IW-1:0] mw_rd,
  input  logic          mw_we,
  input  logic [W-1:0]  mw_val,
  output logic [W-1:0]  res
);

`ifdef ALU_OPERAND_FWD_EN
  // youngest matching producer wins
  always_comb begin
    res = rf_val;
    if (idx != '0 && em_we && em_rd == idx)
      res = em_val;
    else if (idx != '0 && mw_we && mw_rd == idx)
      res = mw_val;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{idx, em_rd, em_we, em_val,
                        mw_rd, mw_we, mw_val};
  assign res = rf_val;
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: resolves ALU operands into a 2-entry skid pair.
// Forwarding muxes are enabled by ALU_OPERAND_FWD_EN.
module alu_operand_stage
  import rv32i_ex_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  alu_operand_stage_if.slave bus
);

  state_t          state_q, state_d;
  payload_t        main_q, skid_q, in_pl;
  logic            in_ready_q;
  logic            in_fire;
  logic            load_main, load_skid, skid_to_main;
  logic [XLEN-1:0] rs1_res, rs2_res;

  assign in_fire = bus.in_valid & in_ready_q;

  operand_fwd_mux u_fwd_rs1 (
    .idx    (bus.rs1_idx),
    .rf_val (bus.rs1_val),
    .em_rd  (bus.fwd_em_rd),
    .em_we  (bus.fwd_em_we),
    .em_val (bus.fwd_em_val),
    .mw_rd  (bus.fwd_mw_rd),
    .mw_we  (bus.fwd_mw_we),
    .mw_val (bus.fwd_mw_val),
    .res    (rs1_res)
  );

  operand_fwd_mux u_fwd_rs2 (
    .idx    (bus.rs2_idx),
    .rf_val (bus.rs2_val),
    .em_rd  (bus.fwd_em_rd),
    .em_we  (bus.fwd_em_we),
    .em_val (bus.fwd_em_val),
    .mw_rd  (bus.fwd_mw_rd),
    .mw_we  (bus.fwd_mw_we),
    .mw_val (bus.fwd_mw_val),
    .res    (rs2_res)
  );

  // select operand sources after forwarding and pack the payload
  always_comb begin
    in_pl = '0;
    unique case (bus.sel_a)
      SEL_A_RS1: in_pl.a_op = rs1_res;
      SEL_A_PC:  in_pl.a_op = bus.pc;
      default:   in_pl.a_op = '0;
    endcase
    unique case (bus.sel_b)
      SEL_B_RS2:  in_pl.b_op = rs2_res;
      SEL_B_FOUR: in_pl.b_op = CONST_FOUR;
      default:    in_pl.b_op = bus.imm;
    endcase
    in_pl.func    = bus.func_in;
    in_pl.sub_sra = bus.sub_sra_in;
    in_pl.rd      = bus.rd_in;
    in_pl.rd_we   = bus.rd_we_in;
  end

  // occupancy FSM: which register loads and where we go next
  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d   = ST_BUSY;
          load_main = 1'b1;
        end
      end
      ST_BUSY: begin
        if (in_fire && bus.out_ready) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (bus.out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (bus.out_ready) begin
          state_d      = ST_BUSY;
          skid_to_main = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (bus.flush) begin
      state_d      = ST_EMPTY;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
    end
  end

  // state register and registered upstream ready
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  // payload registers load only on acceptance or skid drain
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)
        main_q <= in_pl;
      else if (skid_to_main)
        main_q <= skid_q;
      if (bus.flush)
        main_q.rd_we <= 1'b0;
      if (load_skid)
        skid_q <= in_pl;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.a_op      = main_q.a_op;
  assign bus.b_op      = main_q.b_op;
  assign bus.func      = main_q.func;
  assign bus.sub_sra   = main_q.sub_sra;
  assign bus.rd        = main_q.rd;
  assign bus.rd_we     = main_q.rd_we;

endmodule
